// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (signed/unsigned quotient and remainder).
// One quotient bit per cycle. Every trial subtraction goes through the single
// WIDTH+1 bit arithmetic unit 'au'. Division by zero and signed overflow
// finish early, without entering the bit loop.

// au: add/subtract unit with an unsigned less-than flag (mode=1 subtracts).
module au #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             unsigned_compare
);

  assign out              = mode ? (ra - rb) : (ra + rb);
  assign unsigned_compare = (ra < rb);

endmodule

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    LOOP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dmag;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_qsign;
  logic             r_rsign;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_signed_op;
  logic             w_rem_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_au_ra;
  logic [WIDTH:0]   w_au_rb;
  logic [WIDTH:0]   w_au_out;
  logic             w_au_lt;
  logic             w_unused_au_msb;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_accept;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // op[0]=1 selects the unsigned variants; op[1]=1 selects the remainder
  assign w_signed_op = ~r_op[0];
  assign w_rem_op    = r_op[1];
  assign w_a_neg     = w_signed_op & r_a[WIDTH-1];
  assign w_b_neg     = w_signed_op & r_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~r_a + ONE) : r_a;
  assign w_b_mag     = w_b_neg ? (~r_b + ONE) : r_b;
  assign w_div_zero  = (r_b == ZERO);
  assign w_ovf       = w_signed_op & (r_a == MIN_NEG) & (r_b == ALL_ONE);

  // The partial remainder shifted left with the next dividend bit can need
  // WIDTH+1 bits, so the trial subtraction is done one bit wider.
  assign w_au_ra = {r_r, r_q[WIDTH-1]};
  assign w_au_rb = {1'b0, r_dmag};

  au #(.WIDTH(WIDTH + 1)) u_au (
    .ra               (w_au_ra),
    .rb               (w_au_rb),
    .mode             (1'b1),
    .out              (w_au_out),
    .unsigned_compare (w_au_lt)
  );

  // A successful trial leaves a difference smaller than the divisor, so its top bit is always 0
  assign w_unused_au_msb = w_au_out[WIDTH];

  assign w_q_fix  = r_qsign ? (~r_q + ONE) : r_q;
  assign w_r_fix  = r_rsign ? (~r_r + ONE) : r_r;
  assign w_accept = start & ((r_state == IDLE) | (r_state == DONE));

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Next-state decode for the divider sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = PREP;
        else       w_next_state = IDLE;
      end
      PREP: begin
        if (w_div_zero || w_ovf) w_next_state = DONE;
        else                     w_next_state = LOOP;
      end
      LOOP: begin
        if (r_cnt == {CW{1'b0}}) w_next_state = FIX;
        else                     w_next_state = LOOP;
      end
      FIX:  w_next_state = DONE;
      DONE: begin
        if (start) w_next_state = PREP;
        else       w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == PREP) || (w_next_state == LOOP) || (w_next_state == FIX);
      r_done  <= (w_next_state == DONE);
    end
  end

  // Datapath: operand capture, magnitude preparation, bit loop and sign fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= 2'b00;
      r_a      <= ZERO;
      r_b      <= ZERO;
      r_dmag   <= ZERO;
      r_r      <= ZERO;
      r_q      <= ZERO;
      r_cnt    <= {CW{1'b0}};
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_result <= ZERO;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_op <= op;
            r_a  <= dividend;
            r_b  <= divisor;
          end
        end
        PREP: begin
          if (w_div_zero) begin
            r_result <= w_rem_op ? r_a : ALL_ONE;
          end else if (w_ovf) begin
            r_result <= w_rem_op ? ZERO : r_a;
          end else begin
            r_r     <= ZERO;
            r_q     <= w_a_mag;
            r_dmag  <= w_b_mag;
            r_cnt   <= CW'(WIDTH - 1);
            r_qsign <= w_a_neg ^ w_b_neg;
            r_rsign <= w_a_neg;
          end
        end
        LOOP: begin
          r_r <= w_au_lt ? w_au_ra[WIDTH-1:0] : w_au_out[WIDTH-1:0];
          r_q <= {r_q[WIDTH-2:0], ~w_au_lt};
          if (r_cnt != {CW{1'b0}}) r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_result <= w_rem_op ? w_r_fix : w_q_fix;
        end
        default: begin
          r_op <= r_op;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (WIDTH=32).
module tb_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ex;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Issue one op (called #1 after a rising edge); edges counts the start edge as 1
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int edges);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 1;
    dividend = $urandom(); divisor = $urandom(); op = 2'($urandom_range(3, 0));
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done) edges = -1;
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    #3;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    vec_t v[7];
    logic [W-1:0] r;
    int e;
    v[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         35};
    v[1] = '{OP_REMU, 32'd100,        32'd7,          32'd2,          35};
    v[2] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   35};
    v[3] = '{OP_DIVU, 32'hFFFFFFFF,   32'h80000001,   32'd1,          35};
    v[4] = '{OP_REMU, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE,   35};
    v[5] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          35};
    v[6] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   35};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, e);
      checks++; if (r !== v[i].ex) begin errors++; $display("FAIL unsigned_result[%0d]: got %h want %h", i, r, v[i].ex); end
      checks++; if (e != v[i].lat) begin errors++; $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, e, v[i].lat); end
    end
    // result must hold while inputs wander
    for (int k = 0; k < 3; k++) begin
      dividend = $urandom(); divisor = $urandom();
      @(posedge clk); #1;
    end
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL result_hold: got %h want 80000000", result); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_flags: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_signed();
    vec_t v[6];
    logic [W-1:0] r;
    int e;
    v[0] = '{OP_DIV, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 35};
    v[1] = '{OP_REM, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 35};
    v[2] = '{OP_REM, 32'd7,        32'hFFFFFFFE,   32'd1,        35};
    v[3] = '{OP_DIV, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 35};
    v[4] = '{OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,       35};
    v[5] = '{OP_REM, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'hFFFFFFFE, 35};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, e);
      checks++; if (r !== v[i].ex) begin errors++; $display("FAIL signed_result[%0d]: got %h want %h", i, r, v[i].ex); end
      checks++; if (e != v[i].lat) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, e, v[i].lat); end
    end
  endtask

  task automatic test_special();
    vec_t v[6];
    logic [W-1:0] r;
    int e;
    v[0] = '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 2};
    v[1] = '{OP_REMU, 32'd5,        32'd0,        32'd5,        2};
    v[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    v[3] = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    v[4] = '{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    v[5] = '{OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, e);
      checks++; if (r !== v[i].ex) begin errors++; $display("FAIL special_result[%0d]: got %h want %h", i, r, v[i].ex); end
      checks++; if (e != v[i].lat) begin errors++; $display("FAIL special_latency[%0d]: got %0d want %0d", i, e, v[i].lat); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int e;
    op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; e = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      e++;
    end
    op = OP_REMU; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    e++; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
    while (!done && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    checks++; if (e != 35) begin errors++; $display("FAIL ignore_latency: got %0d want 35", e); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL ignore_result: got %h want %h", result, 32'd14); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ignore_single_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    int e;
    run_op(OP_DIVU, 32'd1000, 32'd10, r, e);
    checks++; if (r !== 32'd100) begin errors++; $display("FAIL b2b_first: got %h want %h", r, 32'd100); end
    op = OP_REMU; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; e = 1;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); end
    while (!done && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    checks++; if (e != 35) begin errors++; $display("FAIL b2b_latency: got %0d want 35", e); end
    checks++; if (result !== 32'd6) begin errors++; $display("FAIL b2b_result: got %h want %h", result, 32'd6); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] r;
    int e;
    int pulses;
    op = OP_DIV; dividend = 32'hFFFFFFF9; divisor = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    run_op(OP_REM, 32'd7, 32'hFFFFFFFE, r, e);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL abort_next_result: got %h want %h", r, 32'd1); end
    checks++; if (e != 35)     begin errors++; $display("FAIL abort_next_latency: got %0d want 35", e); end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
